// File: rtl/dec2x4_reg.sv
// dec2x4_reg: 2-to-4 one-hot decoder feeding a 2-entry valid/ready FIFO,
// with one saturating event counter per decoded output line.
module dec2x4_reg #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       dec_i,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       dec_o,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [1:0]       cnt_sel,
    output logic [CNT_W-1:0] cnt_o,
    input  logic             clr_cnt
);

    localparam logic [1:0] DEPTH = 2'd2;

    // FIFO bookkeeping
    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [3:0] mem_q [0:1];

    logic       push;
    logic       pop;
    logic [3:0] onehot;

    // Per-line counter values gathered for the read-out mux
    logic [CNT_W-1:0] cnt_vec [0:3];

    // Handshake flags derive only from the registered occupancy, so there is
    // no combinational path from out_ready or in_valid to in_ready.
    assign in_ready  = (count_q != DEPTH);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Binary code to one-hot line
    always_comb begin
        onehot = 4'b0000;
        case (dec_i)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            default: onehot = 4'b1000;
        endcase
    end

    // Next-state for occupancy and pointers from the push/pop pair
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Occupancy and pointer registers; reset drops any queued entries
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only observed while occupancy covers them,
    // so the data itself needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= onehot;
        end
    end

    // Head entry is gated to zero whenever the queue is empty
    always_comb begin
        dec_o = 4'b0000;
        if (out_valid) begin
            dec_o = mem_q[rd_ptr_q];
        end
    end

    // One saturating counter per decoded line
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_line
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic             hit;

            assign hit = push && (dec_i == 2'(gi));

            // Clear wins over an increment; the counter holds at all-ones
            always_comb begin
                cnt_d = cnt_q;
                if (clr_cnt) begin
                    cnt_d = '0;
                end else if (hit && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            // Counter register
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign cnt_vec[gi] = cnt_q;
        end
    endgenerate

    assign cnt_o = cnt_vec[cnt_sel];

endmodule

// File: tb/tb_dec2x4_reg.sv
// tb_dec2x4_reg: directed stimulus against a queue-based reference model,
// checked every cycle, plus hand-computed spot checks.
module tb_dec2x4_reg;

    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       dec_i;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       dec_o;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_o;
    logic             clr_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    dec2x4_reg #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .dec_i     (dec_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dec_o     (dec_o),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cnt_sel   (cnt_sel),
        .cnt_o     (cnt_o),
        .clr_cnt   (clr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of one-hot values and four plain integer counts
    logic [3:0] m_q[$];
    int         m_cnt[4];
    bit         m_live = 1'b0;

    always @(posedge clk) begin
        bit m_push, m_pop;
        if (rst) begin
            m_q.delete();
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_live = 1'b1;
        end else if (m_live) begin
            m_push = in_valid && (m_q.size() < 2);
            m_pop  = out_ready && (m_q.size() > 0);
            if (clr_cnt) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            end else if (m_push && m_cnt[dec_i] < CNT_MAX) begin
                m_cnt[dec_i] = m_cnt[dec_i] + 1;
            end
            if (m_pop) void'(m_q.pop_front());
            if (m_push) m_q.push_back(4'(1 << dec_i));
        end
    end

    // Every-cycle comparison on the falling edge
    always @(negedge clk) begin
        if (m_live) begin
            check("in_ready",  32'(in_ready),  32'(m_q.size() < 2));
            check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
            check("dec_o",     32'(dec_o),     32'((m_q.size() > 0) ? m_q[0] : 4'b0000));
            check("cnt_o",     32'(cnt_o),     32'(m_cnt[cnt_sel]));
        end
    end

    // Apply one cycle of inputs, let the edge pass, return at edge + 1
    task automatic cyc(input logic r, input logic v, input logic [1:0] code,
                       input logic ordy, input logic clr);
        rst       = r;
        in_valid  = v;
        dec_i     = code;
        out_ready = ordy;
        clr_cnt   = clr;
        @(posedge clk);
        #1;
        n_txn++;
        $display("txn %0d: rst=%0b in_valid=%0b dec_i=%0d out_ready=%0b clr_cnt=%0b -> in_ready=%0b out_valid=%0b dec_o=%b",
                 n_txn, r, v, code, ordy, clr, in_ready, out_valid, dec_o);
    endtask

    task automatic peek_cnt(input string name, input logic [1:0] sel, input int exp);
        cnt_sel = sel;
        #1;
        check(name, 32'(cnt_o), 32'(exp));
    endtask

    // Compact directed tail: {in_valid, code, out_ready, clr_cnt}
    typedef struct {
        logic       v;
        logic [1:0] code;
        logic       ordy;
        logic       clr;
    } vec_t;

    vec_t tail[12] = '{
        '{1'b1, 2'd2, 1'b0, 1'b0}, '{1'b1, 2'd1, 1'b0, 1'b1},
        '{1'b1, 2'd0, 1'b1, 1'b0}, '{1'b1, 2'd3, 1'b1, 1'b0},
        '{1'b0, 2'd0, 1'b1, 1'b0}, '{1'b0, 2'd1, 1'b1, 1'b1},
        '{1'b1, 2'd1, 1'b1, 1'b0}, '{1'b1, 2'd2, 1'b0, 1'b0},
        '{1'b1, 2'd3, 1'b0, 1'b0}, '{1'b0, 2'd0, 1'b1, 1'b0},
        '{1'b0, 2'd0, 1'b1, 1'b0}, '{1'b0, 2'd0, 1'b1, 1'b0}
    };

    initial begin
        rst = 1'b1; in_valid = 1'b0; dec_i = 2'd0; out_ready = 1'b0;
        cnt_sel = 2'd0; clr_cnt = 1'b0;
        #1;

        // Reset state
        cyc(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 2'd2, 1'b1, 1'b1);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dec_o",     32'(dec_o),     32'h0);
        peek_cnt("rst_cnt0", 2'd0, 0);

        // Codes 0..3 back to back with the consumer always ready
        cyc(1'b0, 1'b1, 2'd0, 1'b1, 1'b0);
        check("seq_dec0", 32'(dec_o), 32'h1);
        cyc(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
        check("seq_dec1", 32'(dec_o), 32'h2);
        cyc(1'b0, 1'b1, 2'd2, 1'b1, 1'b0);
        check("seq_dec2", 32'(dec_o), 32'h4);
        cyc(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
        check("seq_dec3", 32'(dec_o), 32'h8);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        check("seq_empty", 32'(out_valid), 32'd0);
        for (int i = 0; i < 4; i++) peek_cnt("seq_cnt", 2'(i), 1);

        // Fill to two entries with the consumer stalled, then drain
        cyc(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'd3, 1'b0, 1'b0);
        check("full_in_ready", 32'(in_ready), 32'd0);
        cyc(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        check("full_head", 32'(dec_o), 32'h4);
        peek_cnt("full_held_cnt1", 2'd1, 1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        check("drain_dec", 32'(dec_o), 32'h8);
        check("drain_in_ready", 32'(in_ready), 32'd1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        check("drain_empty", 32'(out_valid), 32'd0);

        // Push and pop together at occupancy one
        cyc(1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 1'b1, 1'b0);
        check("pp_dec", 32'(dec_o), 32'h2);
        check("pp_valid", 32'(out_valid), 32'd1);
        check("pp_in_ready", 32'(in_ready), 32'd1);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);

        // Saturation of line 3
        for (int i = 0; i < 17; i++) cyc(1'b0, 1'b1, 2'd3, 1'b1, 1'b0);
        peek_cnt("sat_cnt3", 2'd3, 15);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);

        // Clear coinciding with a push of code 0
        cyc(1'b0, 1'b1, 2'd0, 1'b1, 1'b1);
        check("clr_dec", 32'(dec_o), 32'h1);
        peek_cnt("clr_cnt0", 2'd0, 0);
        peek_cnt("clr_cnt3", 2'd3, 0);
        cyc(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            cnt_sel = 2'(i);
            cyc(1'b0, tail[i].v, tail[i].code, tail[i].ordy, tail[i].clr);
        end

        // Reset with two entries queued
        cyc(1'b0, 1'b1, 2'd1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        check("pre_rst_full", 32'(in_ready), 32'd0);
        cyc(1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
        check("rst2_out_valid", 32'(out_valid), 32'd0);
        check("rst2_dec_o",     32'(dec_o),     32'h0);
        check("rst2_in_ready",  32'(in_ready),  32'd1);
        for (int i = 0; i < 4; i++) peek_cnt("rst2_cnt", 2'(i), 0);
        cyc(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
